// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the VGA raster timing generator.
// Defaults describe 640x480@60 driven from a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int unsigned HActiveDef    = 640;
  localparam int unsigned HFrontDef     = 16;
  localparam int unsigned HSyncDef      = 96;
  localparam int unsigned HBackDef      = 48;
  localparam int unsigned VActiveDef    = 480;
  localparam int unsigned VFrontDef     = 10;
  localparam int unsigned VSyncDef      = 2;
  localparam int unsigned VBackDef      = 33;
  localparam bit          SyncPolDef    = 1'b0;
  localparam int unsigned LockStableDef = 1024;

  localparam int unsigned HTotalDef = HActiveDef + HFrontDef + HSyncDef + HBackDef;
  localparam int unsigned VTotalDef = VActiveDef + VFrontDef + VSyncDef + VBackDef;

  // Width of the x/y counters; both totals must fit.
  localparam int unsigned CntW = 10;

  typedef enum logic {
    StWaitLock,
    StRun
  } state_e;

endpackage

// File: rtl/vga_timing_if.sv
// Raster outputs handed from the timing generator (master) to the pixel pipeline (slave).
interface vga_timing_if #(
  parameter int unsigned CntW = 10
);
  logic            running;
  logic            hsync;
  logic            vsync;
  logic            active;
  logic [CntW-1:0] x;
  logic [CntW-1:0] y;
  logic            frame_start;

  modport master (
    output running, hsync, vsync, active, x, y, frame_start
  );

  modport slave (
    input running, hsync, vsync, active, x, y, frame_start
  );
endinterface

// File: rtl/vga_lock_filter.sv
// Synchronizes the asynchronous PLL lock and qualifies it with a saturating stability count.
// lock_ok_o is decoded from the next count so the raster starts on the edge the count is reached.
module vga_lock_filter #(
  parameter int unsigned LockStable = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pll_locked_i,
  output logic lock_ok_o
);

  localparam int unsigned CW = $clog2(LockStable + 1);

  if (LockStable < 1) begin : g_bad_lock_stable
    $error("LockStable must be at least 1");
  end

  logic [1:0]    sync_q;
  logic          lock_s;
  logic [CW-1:0] cnt_q, cnt_d;

  assign lock_s = sync_q[1];

  always_comb begin
    cnt_d = cnt_q;
    if (!lock_s) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LockStable)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked_i};
      cnt_q  <= cnt_d;
    end
  end

  assign lock_ok_o = (cnt_d == CW'(LockStable));

endmodule

// File: rtl/vga_timing.sv
// Lock-qualified raster timing generator: WAIT_LOCK/RUN FSM, x/y counters and registered
// sync/active/frame_start decoded from the next counter values so all outputs stay aligned.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned HActive    = HActiveDef,
  parameter int unsigned HFront     = HFrontDef,
  parameter int unsigned HSync      = HSyncDef,
  parameter int unsigned HBack      = HBackDef,
  parameter int unsigned VActive    = VActiveDef,
  parameter int unsigned VFront     = VFrontDef,
  parameter int unsigned VSync      = VSyncDef,
  parameter int unsigned VBack      = VBackDef,
  parameter bit          SyncPol    = SyncPolDef,
  parameter int unsigned LockStable = LockStableDef
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         pll_locked,
  vga_timing_if.master vga
);

  localparam int unsigned HTotal     = HActive + HFront + HSync + HBack;
  localparam int unsigned VTotal     = VActive + VFront + VSync + VBack;
  localparam int unsigned HSyncStart = HActive + HFront;
  localparam int unsigned HSyncEnd   = HActive + HFront + HSync;
  localparam int unsigned VSyncStart = VActive + VFront;
  localparam int unsigned VSyncEnd   = VActive + VFront + VSync;

  if (HTotal > (1 << CntW) || VTotal > (1 << CntW)) begin : g_bad_geometry
    $error("Raster totals exceed the counter range");
  end

  logic            lock_ok;
  state_e          state_q, state_d;
  logic [CntW-1:0] x_q, x_d, y_q, y_d;
  logic            running_q, running_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            active_q, active_d;
  logic            frame_start_q, frame_start_d;
  logic            hs_win, vs_win;

  vga_lock_filter #(
    .LockStable(LockStable)
  ) u_lock_filter (
    .clk_i       (clock_in),
    .rst_ni      (reset_n),
    .pll_locked_i(pll_locked),
    .lock_ok_o   (lock_ok)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitLock;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLock: if (lock_ok)  state_d = StRun;
      StRun:      if (!lock_ok) state_d = StWaitLock;
      default:    state_d = StWaitLock;
    endcase
  end

  // Counters start at (0,0) on entry to RUN and advance only while already running.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (state_d == StRun && state_q == StRun) begin
      if (x_q == CntW'(HTotal - 1)) begin
        x_d = '0;
        y_d = (y_q == CntW'(VTotal - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
        y_d = y_q;
      end
    end
  end

  assign hs_win = (32'(x_d) >= HSyncStart) && (32'(x_d) < HSyncEnd);
  assign vs_win = (32'(y_d) >= VSyncStart) && (32'(y_d) < VSyncEnd);

  always_comb begin
    running_d     = 1'b0;
    hsync_d       = ~SyncPol;
    vsync_d       = ~SyncPol;
    active_d      = 1'b0;
    frame_start_d = 1'b0;
    if (state_d == StRun) begin
      running_d     = 1'b1;
      hsync_d       = hs_win ? SyncPol : ~SyncPol;
      vsync_d       = vs_win ? SyncPol : ~SyncPol;
      active_d      = (32'(x_d) < HActive) && (32'(y_d) < VActive);
      frame_start_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      x_q           <= '0;
      y_q           <= '0;
      running_q     <= 1'b0;
      hsync_q       <= ~SyncPol;
      vsync_q       <= ~SyncPol;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      running_q     <= running_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.running     = running_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.active      = active_q;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.frame_start = frame_start_q;

endmodule
